jtoutrun_sub_bridge: RTL

//  Main-CPU-side initiator for accesses into the sub CPU bus. Turns a decoded main-CPU cycle

---
 rtl/jtoutrun_sub_bridge.sv | 113 +++++++++++
 1 files changed

// File: rtl/jtoutrun_sub_bridge.sv
// rtl/jtoutrun_sub_bridge.sv - main-CPU initiator into the sub CPU bus
// Requests the sub bus, waits for a settled grant (or times out), then acks the main CPU.
module jtoutrun_sub_bridge #(
  parameter int SETTLE = 3,
  parameter int TOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sub_cs,
  input  logic [18:0] main_A,
  input  logic [1:0]  main_dsn,
  input  logic        main_rnw,
  input  logic [15:0] main_dout,
  input  logic        sub_ok,
  input  logic [15:0] sub_din,
  output logic        sub_br,
  output logic [18:0] br_A,
  output logic [1:0]  br_dsn,
  output logic        br_rnw,
  output logic [15:0] br_dout,
  output logic [15:0] main_din,
  output logic        dtackn,
  output logic        tout_flag
);

  localparam logic [3:0] SETTLE_N = 4'(SETTLE);
  localparam logic [9:0] TOUT_N   = 10'(TOUT);

  typedef enum logic [1:0] {IDLE, GRANT, ACK, RELEASE} state_t;

  state_t     r_state;
  logic [3:0] r_settle;
  logic [9:0] r_tout;

  logic [3:0] w_settle_nx;
  logic [9:0] w_tout_nx;
  logic       w_settled;
  logic       w_expired;

  // sub_ok may pulse a cycle early, so only an unbroken run of SETTLE highs counts
  always_comb begin
    w_settle_nx = sub_ok ? r_settle + 4'd1 : 4'd0;
    w_tout_nx   = (r_tout == 10'h3ff) ? r_tout : r_tout + 10'd1;
    w_settled   = (w_settle_nx == SETTLE_N);
    w_expired   = (w_tout_nx == TOUT_N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_settle  <= 4'd0;
      r_tout    <= 10'd0;
      sub_br    <= 1'b0;
      br_A      <= 19'd0;
      br_dsn    <= 2'b11;
      br_rnw    <= 1'b1;
      br_dout   <= 16'd0;
      main_din  <= 16'hffff;
      dtackn    <= 1'b1;
      tout_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // a grant still high here belongs to the previous access: never reuse it
          if (sub_cs && !sub_ok) begin
            br_A     <= main_A;
            br_dsn   <= main_dsn;
            br_rnw   <= main_rnw;
            br_dout  <= main_dout;
            sub_br   <= 1'b1;
            r_settle <= 4'd0;
            r_tout   <= 10'd0;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          r_settle <= w_settle_nx;
          r_tout   <= w_tout_nx;
          if (!sub_cs) begin
            sub_br  <= 1'b0;
            br_dsn  <= 2'b11;
            br_rnw  <= 1'b1;
            r_state <= RELEASE;
          end else if (w_settled) begin
            if (br_rnw) main_din <= sub_din;
            sub_br  <= 1'b0;
            dtackn  <= 1'b0;
            r_state <= ACK;
          end else if (w_expired) begin
            main_din  <= 16'hffff;
            tout_flag <= 1'b1;
            sub_br    <= 1'b0;
            dtackn    <= 1'b0;
            r_state   <= ACK;
          end
        end
        ACK: begin
          if (!sub_cs) begin
            dtackn  <= 1'b1;
            br_dsn  <= 2'b11;
            br_rnw  <= 1'b1;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!sub_ok) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
